// File: rtl/uart_txn_ctrl.sv
// uart_txn_ctrl: host-command sequencer that owns the uart core's transmitter.
// A write sends {cmd, wr_data[15:8], wr_data[7:0]}. A read sends {cmd} and then
// collects two response bytes, with a per-byte timeout. All outputs are registered.
module uart_txn_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned CNT_W          = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_write,
    input  logic [6:0]  addr,
    input  logic [15:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] rd_data,
    output logic        tx_en,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    input  logic        rx_done,
    input  logic [7:0]  rx_data
);

    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TX_LOAD = 3'd1,
        TX_WAIT = 3'd2,
        RX_WAIT = 3'd3,
        FINISH  = 3'd4,
        FAIL    = 3'd5
    } state_t;

    state_t             r_state;
    logic               r_is_write;
    logic [6:0]         r_addr;
    logic [15:0]        r_wr_data;
    logic [1:0]         r_byte_idx;
    logic               r_rx_idx;
    logic [CNT_W-1:0]   r_timer;
    logic [15:0]        r_shadow;

    state_t             w_state_n;
    logic               w_is_write_n;
    logic [6:0]         w_addr_n;
    logic [15:0]        w_wr_data_n;
    logic [1:0]         w_byte_idx_n;
    logic               w_rx_idx_n;
    logic [CNT_W-1:0]   w_timer_n;
    logic [CNT_W-1:0]   w_timer_inc;
    logic [15:0]        w_shadow_n;
    logic [7:0]         w_tx_byte;
    logic               w_last_byte;
    logic               w_busy_n;
    logic               w_done_n;
    logic               w_error_n;
    logic               w_tx_en_n;
    logic [7:0]         w_tx_data_n;
    logic [15:0]        w_rd_data_n;

    // Last byte of the TX phase: byte 2 for writes, byte 0 (the command) for reads
    assign w_last_byte = r_is_write ? (r_byte_idx == 2'd2) : 1'b1;
    assign w_timer_inc = r_timer + CNT_W'(1);

    // Next-state, datapath and registered-output next values
    always_comb begin
        w_state_n    = r_state;
        w_is_write_n = r_is_write;
        w_addr_n     = r_addr;
        w_wr_data_n  = r_wr_data;
        w_byte_idx_n = r_byte_idx;
        w_rx_idx_n   = r_rx_idx;
        w_timer_n    = r_timer;
        w_shadow_n   = r_shadow;
        w_rd_data_n  = rd_data;
        w_tx_byte    = 8'h00;
        w_tx_data_n  = tx_data;
        w_busy_n     = 1'b0;
        w_done_n     = 1'b0;
        w_error_n    = 1'b0;
        w_tx_en_n    = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_is_write_n = is_write;
                    w_addr_n     = addr;
                    w_wr_data_n  = wr_data;
                    w_byte_idx_n = 2'd0;
                    w_state_n    = TX_LOAD;
                end
            end
            TX_LOAD: begin
                w_state_n = TX_WAIT;
            end
            TX_WAIT: begin
                if (tx_done) begin
                    if (!w_last_byte) begin
                        w_byte_idx_n = r_byte_idx + 2'd1;
                        w_state_n    = TX_LOAD;
                    end else if (r_is_write) begin
                        w_state_n = FINISH;
                    end else begin
                        w_timer_n  = '0;
                        w_rx_idx_n = 1'b0;
                        w_state_n  = RX_WAIT;
                    end
                end
            end
            RX_WAIT: begin
                // A byte arriving on the timeout cycle is still accepted
                if (rx_done) begin
                    w_timer_n = '0;
                    if (r_rx_idx) begin
                        w_shadow_n[7:0] = rx_data;
                        w_state_n       = FINISH;
                    end else begin
                        w_shadow_n[15:8] = rx_data;
                        w_rx_idx_n       = 1'b1;
                    end
                end else begin
                    w_timer_n = w_timer_inc;
                    if (w_timer_inc == TIMER_LAST) begin
                        w_state_n = FAIL;
                    end
                end
            end
            FINISH:  w_state_n = IDLE;
            FAIL:    w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase

        case (w_byte_idx_n)
            2'd0:    w_tx_byte = {w_is_write_n, w_addr_n};
            2'd1:    w_tx_byte = w_wr_data_n[15:8];
            default: w_tx_byte = w_wr_data_n[7:0];
        endcase

        w_tx_en_n = (w_state_n == TX_LOAD);
        w_busy_n  = (w_state_n == TX_LOAD) || (w_state_n == TX_WAIT) ||
                    (w_state_n == RX_WAIT);
        w_done_n  = (w_state_n == FINISH);
        w_error_n = (w_state_n == FAIL);
        if (w_state_n == TX_LOAD) begin
            w_tx_data_n = w_tx_byte;
        end
        if ((w_state_n == FINISH) && !r_is_write) begin
            w_rd_data_n = w_shadow_n;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_is_write <= 1'b0;
            r_addr     <= 7'h00;
            r_wr_data  <= 16'h0000;
            r_byte_idx <= 2'd0;
            r_rx_idx   <= 1'b0;
            r_timer    <= '0;
            r_shadow   <= 16'h0000;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            rd_data    <= 16'h0000;
            tx_en      <= 1'b0;
            tx_data    <= 8'h00;
        end else begin
            r_state    <= w_state_n;
            r_is_write <= w_is_write_n;
            r_addr     <= w_addr_n;
            r_wr_data  <= w_wr_data_n;
            r_byte_idx <= w_byte_idx_n;
            r_rx_idx   <= w_rx_idx_n;
            r_timer    <= w_timer_n;
            r_shadow   <= w_shadow_n;
            busy       <= w_busy_n;
            done       <= w_done_n;
            error      <= w_error_n;
            rd_data    <= w_rd_data_n;
            tx_en      <= w_tx_en_n;
            tx_data    <= w_tx_data_n;
        end
    end

endmodule

// File: tb/tb_uart_txn_ctrl.sv
// Testbench for uart_txn_ctrl: directed transactions, a transaction-level
// reference model checked every cycle, and literal expectations per scenario.
module tb_uart_txn_ctrl;

    localparam int TO = 50;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        start    = 1'b0;
    logic        is_write = 1'b0;
    logic [6:0]  addr     = 7'h00;
    logic [15:0] wr_data  = 16'h0000;
    logic        tx_done  = 1'b0;
    logic        rx_done  = 1'b0;
    logic [7:0]  rx_data  = 8'h00;
    logic        busy, done, error, tx_en;
    logic [15:0] rd_data;
    logic [7:0]  tx_data;

    uart_txn_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(17)) dut (
        .clk(clk), .rst(rst), .start(start), .is_write(is_write), .addr(addr),
        .wr_data(wr_data), .busy(busy), .done(done), .error(error),
        .rd_data(rd_data), .tx_en(tx_en), .tx_data(tx_data),
        .tx_done(tx_done), .rx_done(rx_done), .rx_data(rx_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled mid-cycle
    int          n_txen = 0, n_txdone = 0, n_done = 0, n_err = 0;
    int          c_txen = 0, c_txdone = 0, c_done = 0, c_err = 0, c_rx = 0;
    logic [15:0] rd_at_done = 16'h0;
    logic [7:0]  txq[$];
    always @(negedge clk) begin
        if (tx_en)   begin n_txen++; c_txen = cyc; txq.push_back(tx_data); end
        if (tx_done) begin n_txdone++; c_txdone = cyc; end
        if (done)    begin n_done++; c_done = cyc; rd_at_done = rd_data; end
        if (error)   begin n_err++; c_err = cyc; end
        if (rx_done) c_rx = cyc;
    end

    // UART transmitter stand-in: tx_done 10 cycles after each tx_en
    initial begin
        forever begin
            @(negedge clk);
            if (tx_en && !rst) begin
                repeat (10) @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    // Reference model: expected outputs, updated at each rising edge
    logic        m_busy = 1'b0, m_done = 1'b0, m_error = 1'b0, m_txen = 1'b0;
    logic [7:0]  m_txd = 8'h00;
    logic [15:0] m_rd = 16'h0000;

    task automatic m_reset();
        m_busy = 1'b0; m_done = 1'b0; m_error = 1'b0; m_txen = 1'b0;
        m_txd = 8'h00; m_rd = 16'h0000;
    endtask

    task automatic mstep(output bit rs);
        @(posedge clk);
        rs = rst;
        if (rs) m_reset();
    endtask

    task automatic run_txn(input bit w, input logic [6:0] a, input logic [15:0] d);
        logic [7:0] b [3];
        logic [7:0] sh [2];
        int n, idle;
        bit rs;
        b[0] = {w, a}; b[1] = d[15:8]; b[2] = d[7:0];
        n = w ? 3 : 1;
        m_busy = 1'b1;
        for (int k = 0; k < n; k++) begin
            m_txen = 1'b1; m_txd = b[k];
            mstep(rs); if (rs) return;
            m_txen = 1'b0;
            do begin mstep(rs); if (rs) return; end while (!tx_done);
        end
        if (!w) begin
            for (int j = 0; j < 2; j++) begin
                idle = 0;
                forever begin
                    mstep(rs); if (rs) return;
                    if (rx_done) break;
                    idle++;
                    if (idle == TO - 1) begin
                        m_busy = 1'b0; m_error = 1'b1;
                        mstep(rs); if (rs) return;
                        m_error = 1'b0;
                        return;
                    end
                end
                sh[j] = rx_data;
            end
            m_rd = {sh[0], sh[1]};
        end
        m_busy = 1'b0; m_done = 1'b1;
        mstep(rs); if (rs) return;
        m_done = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (rst) m_reset();
            else if (start) run_txn(is_write, addr, wr_data);
        end
    end

    // Checking and stimulus
    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_end(input int d0, input int e0, input int budget);
        for (int i = 0; i < budget && n_done == d0 && n_err == e0; i++) step();
        chk("end_within_budget", 32'(n_done != d0 || n_err != e0), 32'd1);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_done = 1'b1; rx_data = b;
        step();
        rx_done = 1'b0;
    endtask

    task automatic do_read(input logic [6:0] a, input logic [7:0] b0, input logic [7:0] b1,
                           input bit stray, input int nbytes);
        int t0;
        t0 = n_txdone;
        is_write = 1'b0; addr = a; wr_data = 16'h5555;
        start = 1'b1; step(); start = 1'b0;
        if (stray) begin
            repeat (3) step();
            rx_byte(8'h77);
            start = 1'b1; step(); start = 1'b0;
        end
        for (int i = 0; i < 60 && n_txdone == t0; i++) step();
        chk("read_tx_done_seen", 32'(n_txdone - t0), 32'd1);
        repeat (3) step();
        if (nbytes > 0) rx_byte(b0);
        if (nbytes > 1) begin
            repeat (2) step();
            if (stray) begin start = 1'b1; step(); start = 1'b0; end
            repeat (2) step();
            rx_byte(b1);
        end
    endtask

    initial begin
        int d0, e0, x0, q0, dcy;
        fork
            forever begin
                @(negedge clk);
                if (rst) begin
                    chk("mon_busy",  32'(busy),    32'd0);
                    chk("mon_done",  32'(done),    32'd0);
                    chk("mon_error", 32'(error),   32'd0);
                    chk("mon_txen",  32'(tx_en),   32'd0);
                    chk("mon_txd",   32'(tx_data), 32'd0);
                    chk("mon_rd",    32'(rd_data), 32'd0);
                end else begin
                    chk("mon_busy",  32'(busy),    32'(m_busy));
                    chk("mon_done",  32'(done),    32'(m_done));
                    chk("mon_error", 32'(error),   32'(m_error));
                    chk("mon_txen",  32'(tx_en),   32'(m_txen));
                    chk("mon_rd",    32'(rd_data), 32'(m_rd));
                    if (m_busy) chk("mon_txd", 32'(tx_data), 32'(m_txd));
                end
            end
        join_none

        // Reset state
        repeat (2) step();
        chk("rst_busy",  32'(busy),    32'd0);
        chk("rst_done",  32'(done),    32'd0);
        chk("rst_error", 32'(error),   32'd0);
        chk("rst_txen",  32'(tx_en),   32'd0);
        chk("rst_txd",   32'(tx_data), 32'h00);
        chk("rst_rd",    32'(rd_data), 32'h0000);
        rst = 1'b0;
        repeat (2) step();

        // 1: write 0x12 <- 0xBEEF
        d0 = n_done; e0 = n_err; x0 = n_txen; q0 = txq.size();
        is_write = 1'b1; addr = 7'h12; wr_data = 16'hBEEF;
        start = 1'b1; step(); start = 1'b0;
        chk("t1_first_txen", 32'(tx_en), 32'd1);
        wait_end(d0, e0, 200);
        chk("t1_txen_cnt", 32'(n_txen - x0), 32'd3);
        chk("t1_byte0", 32'(txq[q0]),     32'h92);
        chk("t1_byte1", 32'(txq[q0 + 1]), 32'hBE);
        chk("t1_byte2", 32'(txq[q0 + 2]), 32'hEF);
        chk("t1_done_lat", 32'(c_done - c_txdone), 32'd1);
        chk("t1_no_err", 32'(n_err - e0), 32'd0);
        chk("t1_rd", 32'(rd_data), 32'h0000);
        repeat (3) step();

        // 2: read 0x05 -> 0xCAFE
        d0 = n_done; e0 = n_err; x0 = n_txen; q0 = txq.size();
        do_read(7'h05, 8'hCA, 8'hFE, 1'b0, 2);
        wait_end(d0, e0, 20);
        chk("t2_txen_cnt", 32'(n_txen - x0), 32'd1);
        chk("t2_cmd", 32'(txq[q0]), 32'h05);
        chk("t2_rd_at_done", 32'(rd_at_done), 32'hCAFE);
        chk("t2_done_lat", 32'(c_done - c_rx), 32'd1);
        step();
        chk("t2_busy_after", 32'(busy), 32'd0);
        repeat (2) step();

        // 3: read timeout after one byte
        d0 = n_done; e0 = n_err;
        do_read(7'h05, 8'h11, 8'h00, 1'b0, 1);
        wait_end(d0, e0, 120);
        chk("t3_err_cnt", 32'(n_err - e0), 32'd1);
        chk("t3_no_done", 32'(n_done - d0), 32'd0);
        chk("t3_err_lat", 32'(c_err - c_rx), 32'd50);
        chk("t3_rd_kept", 32'(rd_data), 32'hCAFE);
        repeat (3) step();

        // 4: stray rx_done in IDLE and TX_WAIT, start while busy
        rx_byte(8'h77);
        step();
        d0 = n_done; e0 = n_err; x0 = n_txen;
        do_read(7'h05, 8'hCA, 8'hFE, 1'b1, 2);
        wait_end(d0, e0, 20);
        chk("t4_rd_at_done", 32'(rd_at_done), 32'hCAFE);
        chk("t4_txen_cnt", 32'(n_txen - x0), 32'd1);
        chk("t4_no_err", 32'(n_err - e0), 32'd0);
        repeat (3) step();

        // 5: reset mid-read, then a normal write
        d0 = n_done; e0 = n_err;
        do_read(7'h44, 8'h5A, 8'h00, 1'b0, 1);
        repeat (2) step();
        rst = 1'b1;
        #1;
        chk("t5_busy",  32'(busy),    32'd0);
        chk("t5_rd",    32'(rd_data), 32'h0000);
        chk("t5_txen",  32'(tx_en),   32'd0);
        chk("t5_txd",   32'(tx_data), 32'h00);
        repeat (2) step();
        rst = 1'b0;
        repeat (60) step();
        chk("t5_no_done", 32'(n_done - d0), 32'd0);
        chk("t5_no_err",  32'(n_err - e0),  32'd0);
        d0 = n_done; e0 = n_err; q0 = txq.size();
        is_write = 1'b1; addr = 7'h33; wr_data = 16'h1234;
        start = 1'b1; step(); start = 1'b0;
        wait_end(d0, e0, 200);
        chk("t5_wr_done", 32'(n_done - d0), 32'd1);
        chk("t5_byte0", 32'(txq[q0]),     32'hB3);
        chk("t5_byte2", 32'(txq[q0 + 2]), 32'h34);
        repeat (3) step();

        // 6: start held high through a write
        d0 = n_done; e0 = n_err; q0 = txq.size();
        is_write = 1'b1; addr = 7'h01; wr_data = 16'hA55A;
        start = 1'b1; step();
        wait_end(d0, e0, 200);
        dcy = c_done;
        chk("t6_idle_busy", 32'(busy),  32'd0);
        chk("t6_idle_txen", 32'(tx_en), 32'd0);
        step();
        chk("t6_restart_txen", 32'(tx_en), 32'd1);
        chk("t6_restart_busy", 32'(busy),  32'd1);
        chk("t6_restart_lat",  32'(cyc - dcy), 32'd2);
        start = 1'b0;
        d0 = n_done;
        wait_end(d0, e0, 200);
        chk("t6_second_done", 32'(n_done - d0), 32'd1);
        chk("t6_byte0", 32'(txq[q0 + 3]), 32'h81);
        chk("t6_byte1", 32'(txq[q0 + 4]), 32'hA5);
        chk("t6_byte2", 32'(txq[q0 + 5]), 32'h5A);
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
